// File: rtl/pcie_tlp_pkg.sv
// Shared TLP field definitions and the completion queue entry layout.
package pcie_tlp_pkg;

    localparam logic [7:0] FMT_TYPE_CPL  = 8'h0A;
    localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;

    // Field positions within the 32-bit header DWs.
    localparam int FMT_TYPE_LSB   = 24;   // DW0[31:24]
    localparam int LENGTH_LSB     = 0;    // DW0[9:0]
    localparam int LENGTH_W       = 10;
    localparam int CPL_STATUS_LSB = 13;   // DW1[15:13]
    localparam int TAG_LSB        = 8;    // DW2[15:8]
    localparam int LOWER_ADDR_LSB = 0;    // DW2[6:0]

    localparam int CPL_ENTRY_W = 52;

    // Queue entry, packed MSB first: status, tag, lower_addr, has_data, len_err, data.
    typedef struct packed {
        logic [2:0]  status;
        logic [7:0]  tag;
        logic [6:0]  lower_addr;
        logic        has_data;
        logic        len_err;
        logic [31:0] data;
    } cpl_entry_t;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BODY = 2'd1,
        S_DROP = 2'd2
    } rx_state_t;

    function automatic logic is_cpl(input logic [7:0] fmt_type);
        return (fmt_type == FMT_TYPE_CPL) || (fmt_type == FMT_TYPE_CPLD);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Head reads 0 while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pcie_rx_cpl_parser.sv
// Extracts 3DW completion TLPs from the 64-bit RX stream into an FWFT queue.
module pcie_rx_cpl_parser
    import pcie_tlp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      m_axis_rx_tdata,
    input  logic [7:0]       m_axis_rx_tkeep,
    input  logic             m_axis_rx_tlast,
    input  logic             m_axis_rx_tvalid,
    output logic             m_axis_rx_tready,
    output logic             cpl_valid,
    input  logic             cpl_pop,
    output logic [2:0]       cpl_status,
    output logic [7:0]       cpl_tag,
    output logic [6:0]       cpl_lower_addr,
    output logic             cpl_has_data,
    output logic             cpl_len_err,
    output logic [31:0]      cpl_data,
    output logic [CNT_W-1:0] cpl_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] malformed_count
);
    rx_state_t            state_reg, state_next;
    logic [7:0]           fmt_reg;
    logic [LENGTH_W-1:0]  len_reg;
    logic [2:0]           status_reg;
    logic [CNT_W-1:0]     cpl_cnt_reg, drop_cnt_reg, mal_cnt_reg;
    logic                 hdr_latch, push, inc_cpl, inc_drop, inc_mal;
    logic                 fifo_full, fifo_empty;
    logic                 is_cpld;
    cpl_entry_t           push_entry, head_entry;
    logic                 unused_bits;

    // tkeep and most header bits carry nothing this block needs.
    assign unused_bits = ^{m_axis_rx_tkeep, m_axis_rx_tdata};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_HDR;
        else       state_reg <= state_next;
    end

    // Next state, handshake and per-beat event strobes.
    always_comb begin
        state_next       = state_reg;
        m_axis_rx_tready = 1'b1;
        hdr_latch        = 1'b0;
        push             = 1'b0;
        inc_cpl          = 1'b0;
        inc_drop         = 1'b0;
        inc_mal          = 1'b0;
        case (state_reg)
            S_HDR: begin
                if (m_axis_rx_tvalid) begin
                    if (is_cpl(m_axis_rx_tdata[FMT_TYPE_LSB +: 8])) begin
                        if (m_axis_rx_tlast) begin
                            inc_mal = 1'b1;
                        end else begin
                            hdr_latch  = 1'b1;
                            state_next = S_BODY;
                        end
                    end else begin
                        inc_drop = 1'b1;
                        if (!m_axis_rx_tlast) state_next = S_DROP;
                    end
                end
            end
            S_BODY: begin
                // Hold the committing beat until the queue has room.
                m_axis_rx_tready = !fifo_full;
                if (m_axis_rx_tvalid && !fifo_full) begin
                    push       = 1'b1;
                    inc_cpl    = 1'b1;
                    state_next = m_axis_rx_tlast ? S_HDR : S_DROP;
                end
            end
            S_DROP: begin
                if (m_axis_rx_tvalid && m_axis_rx_tlast) state_next = S_HDR;
            end
            default: state_next = S_HDR;
        endcase
    end

    // Header fields held from DW0/DW1 until the second beat arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_reg    <= '0;
            len_reg    <= '0;
            status_reg <= '0;
        end else if (hdr_latch) begin
            fmt_reg    <= m_axis_rx_tdata[FMT_TYPE_LSB +: 8];
            len_reg    <= m_axis_rx_tdata[LENGTH_LSB +: LENGTH_W];
            status_reg <= m_axis_rx_tdata[32 + CPL_STATUS_LSB +: 3];
        end
    end

    // Build the queue entry from the latched header and the DW2/DW3 beat.
    always_comb begin
        is_cpld               = (fmt_reg == FMT_TYPE_CPLD);
        push_entry            = '0;
        push_entry.status     = status_reg;
        push_entry.tag        = m_axis_rx_tdata[TAG_LSB +: 8];
        push_entry.lower_addr = m_axis_rx_tdata[LOWER_ADDR_LSB +: 7];
        push_entry.has_data   = fmt_reg[6];
        push_entry.len_err    = is_cpld && (len_reg != LENGTH_W'(1));
        push_entry.data       = is_cpld ? m_axis_rx_tdata[63:32] : 32'h0;
    end

    // Wrapping statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpl_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            mal_cnt_reg  <= '0;
        end else begin
            if (inc_cpl)  cpl_cnt_reg  <= cpl_cnt_reg  + CNT_W'(1);
            if (inc_drop) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            if (inc_mal)  mal_cnt_reg  <= mal_cnt_reg  + CNT_W'(1);
        end
    end

    sync_fifo_fwft #(
        .WIDTH (CPL_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (cpl_pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cpl_valid       = !fifo_empty;
    assign cpl_status      = head_entry.status;
    assign cpl_tag         = head_entry.tag;
    assign cpl_lower_addr  = head_entry.lower_addr;
    assign cpl_has_data    = head_entry.has_data;
    assign cpl_len_err     = head_entry.len_err;
    assign cpl_data        = head_entry.data;
    assign cpl_count       = cpl_cnt_reg;
    assign drop_count      = drop_cnt_reg;
    assign malformed_count = mal_cnt_reg;

endmodule

// File: tb/tb_pcie_rx_cpl_parser.sv
// Directed bench for pcie_rx_cpl_parser with a per-TLP reference model.
module tb_pcie_rx_cpl_parser;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [63:0]      m_axis_rx_tdata;
    logic [7:0]       m_axis_rx_tkeep;
    logic             m_axis_rx_tlast;
    logic             m_axis_rx_tvalid;
    logic             m_axis_rx_tready;
    logic             cpl_valid;
    logic             cpl_pop;
    logic [2:0]       cpl_status;
    logic [7:0]       cpl_tag;
    logic [6:0]       cpl_lower_addr;
    logic             cpl_has_data;
    logic             cpl_len_err;
    logic [31:0]      cpl_data;
    logic [CNT_W-1:0] cpl_count;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] malformed_count;

    pcie_rx_cpl_parser #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tready (m_axis_rx_tready),
        .cpl_valid        (cpl_valid),
        .cpl_pop          (cpl_pop),
        .cpl_status       (cpl_status),
        .cpl_tag          (cpl_tag),
        .cpl_lower_addr   (cpl_lower_addr),
        .cpl_has_data     (cpl_has_data),
        .cpl_len_err      (cpl_len_err),
        .cpl_data         (cpl_data),
        .cpl_count        (cpl_count),
        .drop_count       (drop_count),
        .malformed_count  (malformed_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  st;
        logic [7:0]  tag;
        logic [6:0]  la;
        logic        hd;
        logic        le;
        logic [31:0] data;
    } ent_t;

    ent_t             mq[$];
    int               m_pos = 0;          // 0: next beat is a header, 1: completion DW2/DW3 due, 2: skipping
    logic [31:0]      m_h0, m_h1;
    logic [CNT_W-1:0] m_cpl = '0, m_drop = '0, m_mal = '0;
    bit               started = 0;

    function automatic bit m_tready();
        return !(m_pos == 1 && mq.size() == DEPTH);
    endfunction

    task automatic model_step();
        ent_t       e;
        logic [7:0] ft;
        bit         acc, dp;
        if (reset) begin
            mq.delete();
            m_pos = 0; m_cpl = '0; m_drop = '0; m_mal = '0;
            started = 1;
            return;
        end
        acc = m_axis_rx_tvalid && m_tready();
        dp  = cpl_pop && (mq.size() > 0);
        if (acc) begin
            if (m_pos == 0) begin
                ft = m_axis_rx_tdata[31:24];
                if (ft == 8'h0A || ft == 8'h4A) begin
                    if (m_axis_rx_tlast) m_mal++;
                    else begin
                        m_h0 = m_axis_rx_tdata[31:0];
                        m_h1 = m_axis_rx_tdata[63:32];
                        m_pos = 1;
                    end
                end else begin
                    m_drop++;
                    m_pos = m_axis_rx_tlast ? 0 : 2;
                end
            end else if (m_pos == 1) begin
                e.st   = m_h1[15:13];
                e.tag  = m_axis_rx_tdata[15:8];
                e.la   = m_axis_rx_tdata[6:0];
                e.hd   = (m_h0[31:24] == 8'h4A);
                e.le   = e.hd && (m_h0[9:0] != 10'd1);
                e.data = e.hd ? m_axis_rx_tdata[63:32] : 32'h0;
                mq.push_back(e);
                m_cpl++;
                m_pos = m_axis_rx_tlast ? 0 : 2;
            end else if (m_axis_rx_tlast) begin
                m_pos = 0;
            end
        end
        if (dp) void'(mq.pop_front());
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every cycle once reset has been seen.
    initial forever begin
        @(negedge clk);
        if (started) begin
            ent_t h;
            h = '{st: 0, tag: 0, la: 0, hd: 0, le: 0, data: 0};
            if (mq.size() > 0) h = mq[0];
            chk("tready",    m_axis_rx_tready, m_tready());
            chk("valid",     cpl_valid, mq.size() > 0);
            chk("status",    cpl_status, h.st);
            chk("tag",       cpl_tag, h.tag);
            chk("lower_addr", cpl_lower_addr, h.la);
            chk("has_data",  cpl_has_data, h.hd);
            chk("len_err",   cpl_len_err, h.le);
            chk("data",      cpl_data, h.data);
            chk("cpl_count", cpl_count, m_cpl);
            chk("drop_count", drop_count, m_drop);
            chk("mal_count", malformed_count, m_mal);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] hdr(input logic [7:0] ft, input logic [9:0] len, input logic [2:0] st);
        return {16'h0, st, 13'h0, ft, 14'h0, len};
    endfunction

    function automatic logic [63:0] body(input logic [7:0] tag, input logic [6:0] la, input logic [31:0] d);
        return {d, 16'h0, tag, 1'b0, la};
    endfunction

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic beat(input logic [63:0] d, input logic l);
        int n;
        m_axis_rx_tvalid = 1'b1;
        m_axis_rx_tdata  = d;
        m_axis_rx_tlast  = l;
        n = 0;
        @(negedge clk);
        while (!m_axis_rx_tready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout actual=stalled required=accepted at %0t", $time);
        end
        @(posedge clk); #1;
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
    endtask

    task automatic send_cpld(input logic [7:0] tag, input logic [6:0] la, input logic [31:0] d);
        beat(hdr(8'h4A, 10'd1, 3'd0), 1'b0);
        beat(body(tag, la, d), 1'b1);
    endtask

    task automatic pop_one();
        cpl_pop = 1'b1;
        @(posedge clk); #1;
        cpl_pop = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (cpl_valid && n < 20) begin
            @(posedge clk); #1;
            pop_one();
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        m_axis_rx_tdata = '0; m_axis_rx_tkeep = 8'hFF;
        m_axis_rx_tlast = 1'b0; m_axis_rx_tvalid = 1'b0; cpl_pop = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", cpl_valid, 1'b0);
        chk("rst_tready", m_axis_rx_tready, 1'b1);
        chk("rst_count", cpl_count, 16'd0);
        chk("rst_data", cpl_data, 32'h0);
        @(posedge clk); #1;

        // 1: basic CplD
        send_cpld(8'h05, 7'h04, 32'hCAFEBABE);
        @(negedge clk);
        chk("t1_valid", cpl_valid, 1'b1);
        chk("t1_data", cpl_data, 32'hCAFEBABE);
        chk("t1_tag", cpl_tag, 8'h05);
        chk("t1_la", cpl_lower_addr, 7'h04);
        chk("t1_has_data", cpl_has_data, 1'b1);
        chk("t1_len_err", cpl_len_err, 1'b0);
        chk("t1_count", cpl_count, 16'd1);
        @(posedge clk); #1;
        drain();
        $display("T1 CplD tag05 done");

        // 2: MWr dropped, then Cpl with UR
        beat(hdr(8'h40, 10'd1, 3'd0), 1'b0);
        beat(body(8'h00, 7'h00, 32'h12345678), 1'b1);
        beat(hdr(8'h0A, 10'd0, 3'b001), 1'b0);
        beat(body(8'h22, 7'h11, 32'hDEADBEEF), 1'b1);
        @(negedge clk);
        chk("t2_drop", drop_count, 16'd1);
        chk("t2_status", cpl_status, 3'd1);
        chk("t2_has_data", cpl_has_data, 1'b0);
        chk("t2_data", cpl_data, 32'h0);
        @(posedge clk); #1;
        drain();
        $display("T2 MWr drop + Cpl UR done");

        // 3: overfill the queue
        for (int t = 1; t <= 4; t++) send_cpld(8'(t), 7'h00, 32'h100 + t);
        beat(hdr(8'h4A, 10'd1, 3'd0), 1'b0);
        m_axis_rx_tvalid = 1'b1;
        m_axis_rx_tdata  = body(8'h05, 7'h00, 32'h105);
        m_axis_rx_tlast  = 1'b1;
        @(negedge clk);
        chk("t3_stall", m_axis_rx_tready, 1'b0);
        chk("t3_head1", cpl_tag, 8'h01);
        @(posedge clk); #1;
        pop_one();
        @(negedge clk);
        chk("t3_tready_back", m_axis_rx_tready, 1'b1);
        chk("t3_head2", cpl_tag, 8'h02);
        @(posedge clk); #1;
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
        for (int t = 2; t <= 5; t++) begin
            @(negedge clk);
            chk("t3_order", cpl_tag, 8'(t));
            @(posedge clk); #1;
            pop_one();
        end
        @(negedge clk);
        chk("t3_empty", cpl_valid, 1'b0);
        @(posedge clk); #1;
        $display("T3 backpressure + order done");

        // 4: CplD length 4 over three beats, then a Cpl
        beat(hdr(8'h4A, 10'd4, 3'd0), 1'b0);
        beat(body(8'h44, 7'h08, 32'hAAAA5555), 1'b0);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        beat(hdr(8'h0A, 10'd0, 3'd0), 1'b0);
        beat(body(8'h33, 7'h10, 32'h0), 1'b1);
        @(negedge clk);
        chk("t4_tag", cpl_tag, 8'h44);
        chk("t4_len_err", cpl_len_err, 1'b1);
        chk("t4_data", cpl_data, 32'hAAAA5555);
        chk("t4_count", cpl_count, 16'd9);
        @(posedge clk); #1;
        pop_one();
        @(negedge clk);
        chk("t4_next_tag", cpl_tag, 8'h33);
        chk("t4_next_le", cpl_len_err, 1'b0);
        @(posedge clk); #1;
        drain();
        $display("T4 long CplD done");

        // 5: completion ending on its header beat
        beat(hdr(8'h4A, 10'd1, 3'd0), 1'b1);
        @(negedge clk);
        chk("t5_mal", malformed_count, 16'd1);
        chk("t5_no_entry", cpl_valid, 1'b0);
        @(posedge clk); #1;
        send_cpld(8'h66, 7'h01, 32'h66666666);
        @(negedge clk);
        chk("t5_recover", cpl_tag, 8'h66);
        @(posedge clk); #1;
        $display("T5 malformed done");

        // 6: push and pop together at occupancy 2, then reset mid-body
        send_cpld(8'h77, 7'h02, 32'h77777777);
        beat(hdr(8'h4A, 10'd1, 3'd0), 1'b0);
        cpl_pop = 1'b1;
        beat(body(8'h88, 7'h03, 32'h88888888), 1'b1);
        cpl_pop = 1'b0;
        @(negedge clk);
        chk("t6_occ", 64'(mq.size()), 64'd2);
        chk("t6_head", cpl_tag, 8'h77);
        @(posedge clk); #1;
        beat(hdr(8'h4A, 10'd1, 3'd0), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", cpl_valid, 1'b0);
        chk("t6_rst_cpl", cpl_count, 16'd0);
        chk("t6_rst_drop", drop_count, 16'd0);
        chk("t6_rst_mal", malformed_count, 16'd0);
        @(posedge clk); #1;
        send_cpld(8'h99, 7'h05, 32'h99999999);
        @(negedge clk);
        chk("t6_after_rst", cpl_tag, 8'h99);
        chk("t6_after_cnt", cpl_count, 16'd1);
        $display("T6 push/pop + reset done");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
